// File: rtl/d_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : d_mem_arbiter
// Purpose  : Two-master round-robin arbiter in front of the single-port data
//            memory d_mem, with one-cycle read return routing and a bounded
//            bus lock for read-modify-write sequences.
// Revision : 1.0 - initial release
// ============================================================================
module d_mem_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic              i_m0_lock,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic              i_m1_lock,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_mem_wren,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);

    localparam int                CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0]  C_MAX = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_M0   = 2'd1,
        LK_M1   = 2'd2
    } lock_e;

    lock_e              lock_q, lock_d;
    logic               last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               rd_pend_q, rd_pend_d;
    logic               rd_id_q, rd_id_d;

    logic               w_gnt0, w_gnt1, w_any, w_sel, w_we, w_lock;
    logic [CNT_W-1:0]   w_cnt_inc;

    // Grant selection: lock owner only while locked, otherwise round-robin.
    // Grants are suppressed while reset is asserted so memory pins stay quiet.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (i_rst_n) begin
            case (lock_q)
                LK_M0:   w_gnt0 = i_m0_req;
                LK_M1:   w_gnt1 = i_m1_req;
                default: begin
                    if (i_m0_req && i_m1_req) begin
                        if (last_gnt_q) w_gnt0 = 1'b1;
                        else            w_gnt1 = 1'b1;
                    end else begin
                        w_gnt0 = i_m0_req;
                        w_gnt1 = i_m1_req;
                    end
                end
            endcase
        end
        w_any  = w_gnt0 | w_gnt1;
        w_sel  = w_gnt1;
        w_we   = w_sel ? i_m1_we   : i_m0_we;
        w_lock = w_sel ? i_m1_lock : i_m0_lock;
    end

    // Drive the memory pins from the winner; all zero when nothing is granted.
    always_comb begin
        o_mem_wren  = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_gnt0) begin
            o_mem_wren  = i_m0_we;
            o_mem_addr  = i_m0_addr;
            o_mem_wdata = i_m0_wdata;
        end else if (w_gnt1) begin
            o_mem_wren  = i_m1_we;
            o_mem_addr  = i_m1_addr;
            o_mem_wdata = i_m1_wdata;
        end
    end

    // Next-state: round-robin pointer, lock ownership/count and read tag.
    always_comb begin
        lock_d     = lock_q;
        lock_cnt_d = lock_cnt_q;
        last_gnt_d = last_gnt_q;
        rd_pend_d  = w_any & ~w_we;
        rd_id_d    = w_sel;
        w_cnt_inc  = lock_cnt_q + C_ONE;
        if (w_any) begin
            last_gnt_d = w_sel;
            if (!w_lock) begin
                lock_d     = LK_NONE;
                lock_cnt_d = '0;
            end else if (lock_q == LK_NONE) begin
                // Lock taken on this grant; a limit of one releases at once.
                if (C_ONE >= C_MAX) begin
                    lock_d     = LK_NONE;
                    lock_cnt_d = '0;
                end else begin
                    lock_d     = w_sel ? LK_M1 : LK_M0;
                    lock_cnt_d = C_ONE;
                end
            end else if (w_cnt_inc >= C_MAX) begin
                // Forced release; last_gnt = owner hands the next tie over.
                lock_d     = LK_NONE;
                lock_cnt_d = '0;
            end else begin
                lock_cnt_d = w_cnt_inc;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_q     <= LK_NONE;
            lock_cnt_q <= '0;
            last_gnt_q <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_id_q    <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
            last_gnt_q <= last_gnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_id_q    <= rd_id_d;
        end
    end

    // Response routing: read data only reaches the tagged master.
    always_comb begin
        o_m0_gnt    = w_gnt0;
        o_m1_gnt    = w_gnt1;
        o_m0_rvalid = rd_pend_q & ~rd_id_q;
        o_m1_rvalid = rd_pend_q &  rd_id_q;
        o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : '0;
        o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : '0;
        o_busy      = (lock_q != LK_NONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_d_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_mem_arbiter
// Purpose  : Directed self-checking bench for d_mem_arbiter with a behavioural
//            d_mem (synchronous write, one-cycle registered read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_d_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [12:0] m0_addr, m1_addr, mem_addr;
    logic [31:0] m0_wdata, m1_wdata, mem_wdata, mem_rdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_wren, busy;
    logic [31:0] m0_rdata, m1_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:8191];

    always #5 clk = ~clk;

    // Behavioural d_mem
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    d_mem_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_lock(m0_lock),
        .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_lock(m1_lock),
        .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
        .o_mem_wren(mem_wren), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic req, input logic we, input logic lk,
                        input logic [12:0] a, input logic [31:0] d);
        m0_req = req; m0_we = we; m0_lock = lk; m0_addr = a; m0_wdata = d;
    endtask

    task automatic drv1(input logic req, input logic we, input logic lk,
                        input logic [12:0] a, input logic [31:0] d);
        m1_req = req; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;

        // ---- Reset: request present but everything quiet ----
        rst_n = 1'b0;
        drv0(1'b1, 1'b1, 1'b0, 13'd5, 32'hDEADBEEF);
        drv1(1'b0, 1'b0, 1'b0, 13'd0, 32'h0);
        #2;
        chk("rst_gnt0", {31'd0, m0_gnt}, 32'd0);
        chk("rst_wren", {31'd0, mem_wren}, 32'd0);
        chk("rst_addr", {19'd0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rvalid0", {31'd0, m0_rvalid}, 32'd0);
        tick(); tick();
        drv0(1'b0, 1'b0, 1'b0, 13'd0, 32'h0);
        rst_n = 1'b1;

        // ---- Single master: write then read back ----
        tick();
        drv0(1'b1, 1'b1, 1'b0, 13'd0, 32'hA5A5A5A5); #1;
        chk("wr_gnt0", {31'd0, m0_gnt}, 32'd1);
        chk("wr_gnt1", {31'd0, m1_gnt}, 32'd0);
        chk("wr_wren", {31'd0, mem_wren}, 32'd1);
        chk("wr_wdata", mem_wdata, 32'hA5A5A5A5);
        tick();
        drv0(1'b1, 1'b0, 1'b0, 13'd0, 32'h0); #1;
        chk("rd_gnt0", {31'd0, m0_gnt}, 32'd1);
        chk("rd_wren", {31'd0, mem_wren}, 32'd0);
        chk("wr_no_rvalid", {31'd0, m0_rvalid}, 32'd0);
        tick();
        drv0(1'b0, 1'b0, 1'b0, 13'd0, 32'h0); #1;
        chk("rd_rvalid0", {31'd0, m0_rvalid}, 32'd1);
        chk("rd_rdata0", m0_rdata, 32'hA5A5A5A5);
        chk("rd_rvalid1", {31'd0, m1_rvalid}, 32'd0);
        chk("rd_rdata1", m1_rdata, 32'd0);

        // ---- Preload addr2 (m0) and addr1 (m1); last grant ends on m1 ----
        tick();
        drv0(1'b1, 1'b1, 1'b0, 13'd2, 32'h12345678); #1;
        chk("pre_gnt0", {31'd0, m0_gnt}, 32'd1);
        tick();
        drv0(1'b0, 1'b0, 1'b0, 13'd0, 32'h0);
        drv1(1'b1, 1'b1, 1'b0, 13'd1, 32'h5A5A5A5A); #1;
        chk("pre_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("pre_addr", {19'd0, mem_addr}, 32'd1);

        // ---- Contention: alternating grants, correct return routing ----
        tick();
        drv0(1'b1, 1'b0, 1'b0, 13'd1, 32'h0);
        drv1(1'b1, 1'b0, 1'b0, 13'd2, 32'h0); #1;
        chk("ct1_gnt0", {31'd0, m0_gnt}, 32'd1);
        chk("ct1_gnt1", {31'd0, m1_gnt}, 32'd0);
        tick(); #1;
        chk("ct2_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("ct2_gnt0", {31'd0, m0_gnt}, 32'd0);
        chk("ct2_rdata0", m0_rdata, 32'h5A5A5A5A);
        chk("ct2_rvalid1", {31'd0, m1_rvalid}, 32'd0);
        tick(); #1;
        chk("ct3_gnt0", {31'd0, m0_gnt}, 32'd1);
        chk("ct3_rvalid1", {31'd0, m1_rvalid}, 32'd1);
        chk("ct3_rdata1", m1_rdata, 32'h12345678);
        chk("ct3_rdata0", m0_rdata, 32'd0);
        tick(); #1;
        chk("ct4_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("ct4_rdata0", m0_rdata, 32'h5A5A5A5A);
        tick();
        drv0(1'b0, 1'b0, 1'b0, 13'd0, 32'h0);
        drv1(1'b0, 1'b0, 1'b0, 13'd0, 32'h0); #1;
        chk("ct5_rdata1", m1_rdata, 32'h12345678);
        chk("ct5_rvalid0", {31'd0, m0_rvalid}, 32'd0);

        // ---- Lock by m1: 3 locked grants, owner idle gap, unlocked write ----
        tick();
        drv1(1'b1, 1'b0, 1'b1, 13'd1, 32'h0); #1;
        chk("lk1_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("lk1_busy", {31'd0, busy}, 32'd0);
        tick();
        drv0(1'b1, 1'b0, 1'b0, 13'd0, 32'h0); #1;
        chk("lk2_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("lk2_gnt0", {31'd0, m0_gnt}, 32'd0);
        chk("lk2_busy", {31'd0, busy}, 32'd1);
        chk("lk2_rdata1", m1_rdata, 32'h5A5A5A5A);
        tick(); #1;
        chk("lk3_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("lk3_gnt0", {31'd0, m0_gnt}, 32'd0);
        tick();
        drv1(1'b0, 1'b0, 1'b0, 13'd0, 32'h0); #1;
        chk("lkidle_gnt0", {31'd0, m0_gnt}, 32'd0);
        chk("lkidle_busy", {31'd0, busy}, 32'd1);
        tick();
        drv1(1'b1, 1'b1, 1'b0, 13'd2, 32'h12345678); #1;
        chk("lk4_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("lk4_gnt0", {31'd0, m0_gnt}, 32'd0);
        chk("lk4_wren", {31'd0, mem_wren}, 32'd1);
        chk("lk4_busy", {31'd0, busy}, 32'd1);
        tick();
        drv1(1'b0, 1'b0, 1'b0, 13'd0, 32'h0); #1;
        chk("lk5_gnt0", {31'd0, m0_gnt}, 32'd1);
        chk("lk5_busy", {31'd0, busy}, 32'd0);
        tick();
        drv0(1'b0, 1'b0, 1'b0, 13'd0, 32'h0); #1;
        chk("lk6_rdata0", m0_rdata, 32'hA5A5A5A5);

        // ---- Lock timeout: m0 locked for 16 grants, then m1 ----
        tick();
        drv1(1'b1, 1'b0, 1'b0, 13'd2, 32'h0); #1;
        chk("to_pre_gnt1", {31'd0, m1_gnt}, 32'd1);
        tick();
        drv0(1'b1, 1'b0, 1'b1, 13'd1, 32'h0);
        for (int i = 0; i < 17; i++) begin
            #1;
            chk($sformatf("to%0d_gnt0", i), {31'd0, m0_gnt}, (i < 16) ? 32'd1 : 32'd0);
            chk($sformatf("to%0d_gnt1", i), {31'd0, m1_gnt}, (i == 16) ? 32'd1 : 32'd0);
            chk($sformatf("to%0d_busy", i), {31'd0, busy},
                (i >= 1 && i <= 15) ? 32'd1 : 32'd0);
            tick();
        end
        drv0(1'b0, 1'b0, 1'b0, 13'd0, 32'h0);
        drv1(1'b0, 1'b0, 1'b0, 13'd0, 32'h0);

        // ---- Reset mid-read while locked ----
        tick();
        drv0(1'b1, 1'b0, 1'b1, 13'd1, 32'h0); #1;
        chk("rr_gnt0", {31'd0, m0_gnt}, 32'd1);
        tick();
        drv0(1'b0, 1'b0, 1'b0, 13'd0, 32'h0);
        rst_n = 1'b0; #1;
        chk("rr_rvalid0", {31'd0, m0_rvalid}, 32'd0);
        chk("rr_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        drv0(1'b1, 1'b0, 1'b0, 13'd0, 32'h0);
        drv1(1'b1, 1'b0, 1'b0, 13'd1, 32'h0); #1;
        chk("rr_post_rvalid0", {31'd0, m0_rvalid}, 32'd0);
        chk("rr_post_gnt0", {31'd0, m0_gnt}, 32'd1);
        chk("rr_post_gnt1", {31'd0, m1_gnt}, 32'd0);
        tick();
        drv0(1'b0, 1'b0, 1'b0, 13'd0, 32'h0); #1;
        chk("rr_nx_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("rr_nx_rdata0", m0_rdata, 32'hA5A5A5A5);
        tick();
        drv1(1'b0, 1'b0, 1'b0, 13'd0, 32'h0); #1;
        chk("rr_nx_rdata1", m1_rdata, 32'h5A5A5A5A);

        // ---- Idle: nothing driven toward memory ----
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            chk($sformatf("idle%0d_wren", i), {31'd0, mem_wren}, 32'd0);
            chk($sformatf("idle%0d_addr", i), {19'd0, mem_addr}, 32'd0);
            chk($sformatf("idle%0d_gnt", i), {30'd0, m1_gnt, m0_gnt}, 32'd0);
            chk($sformatf("idle%0d_rvalid", i), {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        end

        // ---- Read-back after idle ----
        tick();
        drv0(1'b1, 1'b0, 1'b0, 13'd0, 32'h0); #1;
        chk("rb_gnt0", {31'd0, m0_gnt}, 32'd1);
        tick();
        drv0(1'b0, 1'b0, 1'b0, 13'd0, 32'h0);
        drv1(1'b1, 1'b0, 1'b0, 13'd2, 32'h0); #1;
        chk("rb_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("rb_rdata0", m0_rdata, 32'hA5A5A5A5);
        tick();
        drv1(1'b0, 1'b0, 1'b0, 13'd0, 32'h0); #1;
        chk("rb_rdata1", m1_rdata, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
